// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the ID/EX pipeline slice.
//   - CTRL_W and the bit positions of the decoded control bundle
//   - stage_state_e: ID/EX stage FSM encoding (RUN / BUBBLE)
//   - REG_ZERO: index of the hard-wired zero register
package pipe_pkg;

  localparam int CTRL_W        = 10;

  // Control bundle bit layout
  localparam int CTRL_MEMRD    = 0;
  localparam int CTRL_REGWR    = 1;
  localparam int CTRL_MEMWR    = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUOP_HI = 8;
  localparam int CTRL_BRANCH   = 9;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } stage_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard compare.
// A hazard exists when the instruction in EX is a valid load with a non-zero
// destination and the valid ID instruction actually reads that register.
// Ports:
//   id_valid, ex_valid   - validity of the ID and EX instructions
//   ex_memrd             - EX instruction is a load
//   ex_rw                - EX destination register
//   id_ra, id_rb         - ID source register indices
//   id_use_a, id_use_b   - ID instruction really reads ra / rb
//   hazard               - ID must wait for the load result
module load_use_detect (
  input  logic       id_valid,
  input  logic       ex_valid,
  input  logic       ex_memrd,
  input  logic [4:0] ex_rw,
  input  logic [4:0] id_ra,
  input  logic [4:0] id_rb,
  input  logic       id_use_a,
  input  logic       id_use_b,
  output logic       hazard
);
  import pipe_pkg::*;

  logic src_match;

  assign src_match = (id_use_a && (id_ra == ex_rw)) || (id_use_b && (id_rb == ex_rw));

  // $0 is never written, so a load targeting it cannot create a dependency.
  assign hazard = id_valid & ex_valid & ex_memrd & (ex_rw != REG_ZERO) & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion.
// Captures operands, immediate, destination and control each posedge CLK.
// On a load-use hazard it loads LOAD_USE_BUBBLES bubbles into EX while
// raising id_stall to freeze PC and IF/ID. ex_stall holds the stage,
// ex_flush kills its next contents (flush beats stall beats bubbling).
// Optional build macro PERF_CNT_EN: enables the perf_bubbles/perf_flushes
// counters; without it both ports read 0 and no counter flops exist.
// Ports:
//   CLK, Resetn             - clock, asynchronous active-low reset
//   id_valid, id_pc         - ID instruction valid / PC
//   busA, busB              - register file read data
//   id_ra, id_rb            - source register indices
//   id_use_a, id_use_b      - instruction reads rs / rt
//   id_imm, id_rw, id_ctrl  - immediate, destination, control bundle
//   ex_stall, ex_flush      - downstream hold / branch flush
//   id_stall                - hold PC and IF/ID (combinational)
//   ex_*                    - registered EX-side copies
//   perf_bubbles/flushes    - event counters (PERF_CNT_EN)
module id_ex_stage #(
  parameter int CTRL_W           = pipe_pkg::CTRL_W,
  parameter int LOAD_USE_BUBBLES = 1   // legal range 1..3
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       busA,
  input  logic [31:0]       busB,
  input  logic [4:0]        id_ra,
  input  logic [4:0]        id_rb,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rw,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_stall,
  input  logic              ex_flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rw,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_flushes
);
  import pipe_pkg::*;

  // Remaining bubbles after the first one, loaded when entering BUBBLE.
  localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

  stage_state_e state_reg, state_next;
  logic [1:0]   cnt_reg, cnt_next;
  logic         hazard;
  logic         load_bubble;
  logic         load_id;

  load_use_detect u_detect (
    .id_valid (id_valid),
    .ex_valid (ex_valid),
    .ex_memrd (ex_ctrl[CTRL_MEMRD]),
    .ex_rw    (ex_rw),
    .id_ra    (id_ra),
    .id_rb    (id_rb),
    .id_use_a (id_use_a),
    .id_use_b (id_use_b),
    .hazard   (hazard)
  );

  // Next-state and load-select, in priority order flush > stall > bubble > hazard.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    load_bubble = 1'b0;
    load_id     = 1'b0;
    if (ex_flush) begin
      load_bubble = 1'b1;
      state_next  = RUN;
      cnt_next    = 2'd0;
    end else if (ex_stall) begin
      // hold everything, FSM frozen
    end else if (state_reg == BUBBLE) begin
      load_bubble = 1'b1;
      if (cnt_reg == 2'd1) begin
        state_next = RUN;
      end else begin
        cnt_next = cnt_reg - 2'd1;
      end
    end else if (hazard) begin
      load_bubble = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        state_next = BUBBLE;
        cnt_next   = BUBBLE_RELOAD;
      end
    end else begin
      load_id = 1'b1;
    end
  end

  assign id_stall = ~ex_flush & (ex_stall | (state_reg == BUBBLE) | ((state_reg == RUN) & hazard));

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state_reg <= RUN;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Stage register; a bubble clears every field, not only the control bits.
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_rw    <= '0;
      ex_ctrl  <= '0;
    end else if (load_bubble) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_rw    <= '0;
      ex_ctrl  <= '0;
    end else if (load_id) begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_a     <= busA;
      ex_b     <= busB;
      ex_imm   <= id_imm;
      ex_rw    <= id_rw;
      ex_ctrl  <= id_ctrl;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] perf_bubbles_reg;
  logic [31:0] perf_flushes_reg;
  logic        bubble_taken;

  // Flush bubbles are counted as flushes, not as load-use bubbles.
  assign bubble_taken = load_bubble & ~ex_flush;

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      perf_bubbles_reg <= '0;
      perf_flushes_reg <= '0;
    end else begin
      if (bubble_taken) perf_bubbles_reg <= perf_bubbles_reg + 32'd1;
      if (ex_flush)     perf_flushes_reg <= perf_flushes_reg + 32'd1;
    end
  end

  assign perf_bubbles = perf_bubbles_reg;
  assign perf_flushes = perf_flushes_reg;
`else
  assign perf_bubbles = 32'd0;
  assign perf_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage.
// The driver applies stimulus on the falling edge, predicts the DUT outputs
// from a behavioural model (EX contents plus a count of bubbles still owed)
// and queues the prediction; the monitor pops and compares shortly after
// each falling edge. Honours PERF_CNT_EN for the perf counter expectations.
`timescale 1ns/1ps
module tb_id_ex_stage;

  localparam int CW  = 10;
  localparam int LUB = 3;
  localparam logic [CW-1:0] C_LOAD = CW'(1) << pipe_pkg::CTRL_MEMRD;
  localparam logic [CW-1:0] C_ALU  = CW'(10'h032);

  logic          CLK = 1'b0;
  logic          Resetn = 1'b1;
  logic          id_valid = 1'b0;
  logic [31:0]   id_pc = '0, busA = '0, busB = '0, id_imm = '0;
  logic [4:0]    id_ra = '0, id_rb = '0, id_rw = '0;
  logic          id_use_a = 1'b0, id_use_b = 1'b0;
  logic [CW-1:0] id_ctrl = '0;
  logic          ex_stall = 1'b0, ex_flush = 1'b0;
  logic          id_stall, ex_valid;
  logic [31:0]   ex_pc, ex_a, ex_b, ex_imm, perf_bubbles, perf_flushes;
  logic [4:0]    ex_rw;
  logic [CW-1:0] ex_ctrl;

  always #5 CLK = ~CLK;

  id_ex_stage #(.CTRL_W(CW), .LOAD_USE_BUBBLES(LUB)) dut (
    .CLK(CLK), .Resetn(Resetn), .id_valid(id_valid), .id_pc(id_pc),
    .busA(busA), .busB(busB), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_imm(id_imm), .id_rw(id_rw),
    .id_ctrl(id_ctrl), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a),
    .ex_b(ex_b), .ex_imm(ex_imm), .ex_rw(ex_rw), .ex_ctrl(ex_ctrl),
    .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
  );

  typedef struct packed {
    logic          stall;
    logic          valid;
    logic [31:0]   pc, a, b, imm;
    logic [4:0]    rw;
    logic [CW-1:0] ctrl;
    logic [31:0]   bub, flu;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model: what EX holds, and how many more bubbles are owed.
  logic          m_valid;
  logic [31:0]   m_pc, m_a, m_b, m_imm, m_bub, m_flu;
  logic [4:0]    m_rw;
  logic [CW-1:0] m_ctrl;
  int            m_owed;

  // Stimulus for the next cycle.
  logic          s_valid, s_use_a, s_use_b, s_stall, s_flush;
  logic [31:0]   s_pc, s_busa, s_busb, s_imm;
  logic [4:0]    s_ra, s_rb, s_rw;
  logic [CW-1:0] s_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_a = '0; m_b = '0; m_imm = '0;
    m_rw = '0; m_ctrl = '0; m_owed = 0; m_bub = '0; m_flu = '0;
  endtask

  task automatic model_bubble();
    m_valid = 1'b0; m_pc = '0; m_a = '0; m_b = '0; m_imm = '0;
    m_rw = '0; m_ctrl = '0;
  endtask

  task automatic set_stim(input logic v, input logic [4:0] ra, input logic ua,
                          input logic [4:0] rb, input logic ub, input logic [4:0] rw,
                          input logic [CW-1:0] ctrl, input logic st, input logic fl);
    s_valid = v; s_ra = ra; s_use_a = ua; s_rb = rb; s_use_b = ub;
    s_rw = rw; s_ctrl = ctrl; s_stall = st; s_flush = fl;
    s_pc = $urandom; s_busa = $urandom; s_busb = $urandom; s_imm = $urandom;
  endtask

  task automatic rand_stim();
    s_valid = ($urandom_range(0, 7) != 0);
    s_pc = $urandom; s_busa = $urandom; s_busb = $urandom; s_imm = $urandom;
    s_rw   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    s_ctrl = CW'($urandom);
    s_ra   = ($urandom_range(0, 1) == 1) ? m_rw : 5'($urandom_range(0, 31));
    s_rb   = ($urandom_range(0, 1) == 1) ? m_rw : 5'($urandom_range(0, 31));
    s_use_a = $urandom_range(0, 1) == 1;
    s_use_b = $urandom_range(0, 1) == 1;
    s_stall = ($urandom_range(0, 99) < 15);
    s_flush = ($urandom_range(0, 99) < 8);
  endtask

  // One clock: apply stimulus, queue the prediction, advance the model.
  task automatic cycle();
    exp_t e;
    logic hz;
    @(negedge CLK);
    Resetn = 1'b1;
    id_valid = s_valid; id_pc = s_pc; busA = s_busa; busB = s_busb;
    id_ra = s_ra; id_rb = s_rb; id_use_a = s_use_a; id_use_b = s_use_b;
    id_imm = s_imm; id_rw = s_rw; id_ctrl = s_ctrl;
    ex_stall = s_stall; ex_flush = s_flush;

    hz = m_valid && s_valid && m_ctrl[pipe_pkg::CTRL_MEMRD] && (m_rw != 5'd0) &&
         ((s_use_a && s_ra == m_rw) || (s_use_b && s_rb == m_rw));
    e.stall = !s_flush && (s_stall || (m_owed > 0) || hz);
    e.valid = m_valid; e.pc = m_pc; e.a = m_a; e.b = m_b; e.imm = m_imm;
    e.rw = m_rw; e.ctrl = m_ctrl;
`ifdef PERF_CNT_EN
    e.bub = m_bub; e.flu = m_flu;
`else
    e.bub = '0; e.flu = '0;
`endif
    exp_q.push_back(e);

    if (s_flush) begin
      model_bubble(); m_owed = 0; m_flu = m_flu + 32'd1;
    end else if (s_stall) begin
      // EX contents and owed bubbles unchanged
    end else if (m_owed > 0) begin
      model_bubble(); m_owed = m_owed - 1; m_bub = m_bub + 32'd1;
    end else if (hz) begin
      model_bubble(); m_owed = LUB - 1; m_bub = m_bub + 32'd1;
    end else begin
      m_valid = s_valid; m_pc = s_pc; m_a = s_busa; m_b = s_busb;
      m_imm = s_imm; m_rw = s_rw; m_ctrl = s_ctrl;
    end
  endtask

  // Asynchronous reset pulse a few ns into the current cycle.
  task automatic do_reset();
    #3;
    ex_stall = 1'b0; ex_flush = 1'b0;
    Resetn = 1'b0;
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_a", ex_a, 32'd0);
    check("rst_ex_b", ex_b, 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_rw", 32'(ex_rw), 32'd0);
    check("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    check("rst_id_stall", 32'(id_stall), 32'd0);
    check("rst_perf_bubbles", perf_bubbles, 32'd0);
    check("rst_perf_flushes", perf_flushes, 32'd0);
    model_reset();
  endtask

  always @(negedge CLK) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("id_stall", 32'(id_stall), 32'(mon_e.stall));
      check("ex_valid", 32'(ex_valid), 32'(mon_e.valid));
      check("ex_pc", ex_pc, mon_e.pc);
      check("ex_a", ex_a, mon_e.a);
      check("ex_b", ex_b, mon_e.b);
      check("ex_imm", ex_imm, mon_e.imm);
      check("ex_rw", 32'(ex_rw), 32'(mon_e.rw));
      check("ex_ctrl", 32'(ex_ctrl), 32'(mon_e.ctrl));
      check("perf_bubbles", perf_bubbles, mon_e.bub);
      check("perf_flushes", perf_flushes, mon_e.flu);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    set_stim(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    do_reset();

    // Capture after reset release.
    set_stim(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, C_ALU, 1'b0, 1'b0);
    s_busa = 32'h11; s_busb = 32'h22;
    cycle();

    // Load to r8, then a dependent instruction: LUB bubbles, then capture.
    set_stim(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, C_LOAD, 1'b0, 1'b0);
    cycle();
    set_stim(1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 5'd9, C_ALU, 1'b0, 1'b0);
    repeat (LUB + 2) cycle();

    // Same, with a downstream hold during the second bubble.
    set_stim(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, C_LOAD, 1'b0, 1'b0);
    cycle();
    set_stim(1'b1, 5'd4, 1'b0, 5'd8, 1'b1, 5'd10, C_ALU, 1'b0, 1'b0);
    cycle();
    cycle();
    s_stall = 1'b1; cycle();
    s_stall = 1'b0; repeat (4) cycle();

    // Flush with stall while bubbling.
    set_stim(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, C_LOAD, 1'b0, 1'b0);
    cycle();
    set_stim(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd11, C_ALU, 1'b0, 1'b0);
    cycle();
    cycle();
    s_stall = 1'b1; s_flush = 1'b1; cycle();
    s_stall = 1'b0; s_flush = 1'b0; repeat (2) cycle();

    // Load to $0 never stalls a reader of $0.
    set_stim(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, C_LOAD, 1'b0, 1'b0);
    cycle();
    set_stim(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, C_ALU, 1'b0, 1'b0);
    repeat (2) cycle();

    // Four-cycle hold with changing ID inputs.
    for (int i = 0; i < 4; i++) begin
      set_stim(1'b1, 5'(i), 1'b1, 5'(i + 1), 1'b0, 5'(i + 13), C_ALU, 1'b1, 1'b0);
      cycle();
    end
    s_stall = 1'b0; cycle();

    // Reset in the middle of a bubble sequence.
    set_stim(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, C_LOAD, 1'b0, 1'b0);
    cycle();
    set_stim(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd14, C_ALU, 1'b0, 1'b0);
    cycle();
    cycle();
    do_reset();
    set_stim(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd15, C_ALU, 1'b0, 1'b0);
    repeat (2) cycle();

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      rand_stim();
      cycle();
    end

    #5;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage of the 5-stage CPU. Sits directly downstream of the register file's read ports (busA/busB) and the decoder, and feeds the EX stage.
- Captures operands, immediate, destination and control on each posedge CLK.
- Detects load-use hazards and inserts a configurable number of bubbles while stalling IF/ID.
- Honours a downstream hold (ex_stall) and a branch flush (ex_flush).

Parameters:
CTRL_W, 10, width of the control bundle (bit layout in the package)
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3

Ports:
CLK  input  1  clock; all state updates on posedge
Resetn  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_pc  input  32  PC of the ID instruction
busA  input  32  register file read data 1
busB  input  32  register file read data 2
id_ra  input  5  source register A index
id_rb  input  5  source register B index
id_use_a  input  1  instruction reads rs
id_use_b  input  1  instruction reads rt
id_imm  input  32  extended immediate
id_rw  input  5  destination register
id_ctrl  input  CTRL_W  decoded control bundle
ex_stall  input  1  EX/MEM cannot accept; hold this stage
ex_flush  input  1  taken branch/jump resolved; kill this stage's next contents
id_stall  output  1  hold PC and IF/ID this cycle (combinational)
ex_valid  output  1  EX instruction valid
ex_pc  output  32  registered id_pc
ex_a  output  32  registered busA
ex_b  output  32  registered busB
ex_imm  output  32  registered id_imm
ex_rw  output  5  registered id_rw
ex_ctrl  output  CTRL_W  registered id_ctrl
perf_bubbles  output  32  count of load-use bubbles inserted
perf_flushes  output  32  count of flushes applied

Behaviour:
- Reset: Resetn low asynchronously clears every register. Resulting output values: ex_valid=0; ex_pc, ex_a, ex_b, ex_imm, ex_rw, ex_ctrl=0; state=RUN; cnt=0; perf counters=0; id_stall=0.
- Bubble definition: ex_valid=0, ex_ctrl=0, ex_rw=0. Data fields are don't-care but are driven 0.
- hazard (combinational): asserted when all of the following hold:
  - id_valid and ex_valid
  - ex_ctrl[CTRL_MEMRD]
  - ex_rw != 0
  - (id_use_a and id_ra == ex_rw) or (id_use_b and id_rb == ex_rw)
- State machine: RUN and BUBBLE, with a 2-bit counter cnt.
- Per-posedge priority, highest first:
  1. ex_flush: load bubble; state := RUN; cnt := 0. Overrides stall, hazard and BUBBLE state.
  2. ex_stall: hold all registers; state and cnt frozen.
  3. state=BUBBLE: load bubble. If cnt == 1 then state := RUN, else cnt := cnt - 1.
  4. RUN and hazard: load bubble. If LOAD_USE_BUBBLES > 1 then state := BUBBLE and cnt := LOAD_USE_BUBBLES - 1.
  5. Otherwise: load ID fields; ex_valid := id_valid.
- id_stall = ~ex_flush & (ex_stall | state==BUBBLE | (state==RUN & hazard)).
- Latency: one cycle from ID inputs to EX outputs.
- Register $0: never generates a hazard; the ex_rw != 0 term guarantees this.
- Write-before-read: the register file writes on negedge, so busA/busB already reflect same-cycle writeback at the posedge capture. No bypass in this block.
- Reset mid-BUBBLE: returns to RUN; no residual stall.

Optional Feature:
PERF_CNT_EN
- Defined:
  - perf_bubbles increments on every bubble loaded by rule 3 or 4.
  - perf_flushes increments on every rule-1 cycle.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: both ports are present and tied to 0; no counter flops are synthesised.

Decomposition:
- Package pipe_pkg holds:
  - CTRL_W
  - control bit indices: CTRL_MEMRD=0, CTRL_REGWR=1, CTRL_MEMWR=2, CTRL_MEMTOREG=3, CTRL_ALUSRC=4, CTRL_ALUOP=8:5, CTRL_BRANCH=9
  - state encoding: RUN=0, BUBBLE=1
- One sub-module, load_use_detect: the combinational hazard compare. The stage register and FSM stay in id_ex_stage.

Test Plan:
1. Reset pulse (Resetn low mid-cycle, asynchronous), then release; drive id_valid=1, busA=0x11, busB=0x22, id_rw=5 -> all outputs 0 during reset; one posedge after release, ex_a=0x11, ex_b=0x22, ex_rw=5, ex_valid=1.
2. EX holds a load (ex_rw=8, MEMRD=1); ID instruction has id_ra=8, id_use_a=1; LOAD_USE_BUBBLES=1 -> id_stall=1 for one cycle and next ex_valid=0; the following posedge captures the ID instruction with ex_valid=1; perf_bubbles=1 (PERF_CNT_EN defined).
3. Same as 2 with LOAD_USE_BUBBLES=3 -> id_stall high 3 cycles and 3 consecutive bubbles, then normal load. Repeat with ex_stall=1 during the 2nd bubble -> stall extends by 1 cycle and the counter is frozen.
4. Load with ex_rw=0 and id_ra=0, id_use_a=1 -> no hazard, id_stall=0.
5. ex_flush=1 while in BUBBLE and with ex_stall=1 -> next cycle ex_valid=0, state RUN, id_stall=0 during the flush cycle, perf_flushes +1.
6. ex_stall=1 for 4 cycles with changing ID inputs -> EX outputs unchanged, id_stall=1 throughout.
